// File: rtl/keypad_matrix_emu.sv
// Behavioural 4x4 matrix keypad: answers an active-low column scan with active-low
// row returns while emulating press, optional contact bounce, hold and release.
module keypad_matrix_emu #(
  parameter int CLK_DIV   = 100000,
  parameter int BOUNCE_MS = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  col,
  output logic [3:0]  row,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  key_code,
  input  logic [15:0] hold_ms,
  input  logic        bounce_en,
  output logic        pressed,
  output logic        done
);

  localparam int              PW          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX   = PW'(CLK_DIV - 1);
  localparam logic [15:0]     BOUNCE_LAST = 16'(BOUNCE_MS - 1);

  typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_q, ms_d;
  logic [7:0]    lfsr_q, lfsr_d;
  logic [3:0]    key_q, key_d;
  logic [15:0]   hold_q, hold_d;
  logic          ben_q, ben_d;
  logic          pressed_q, pressed_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          tick, in_bounce, last_bounce_next;

  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    state_d = state_q;
    key_d   = key_q;
    hold_d  = hold_q;
    ben_d   = ben_q;

    case (state_q)
      IDLE: if (req_valid) begin
        key_d   = key_code;
        hold_d  = hold_ms;
        ben_d   = bounce_en;
        state_d = bounce_en ? BOUNCE_IN : HOLD;
      end
      BOUNCE_IN:  if (tick && ms_q == BOUNCE_LAST) state_d = HOLD;
      HOLD: if (hold_q == 16'd0 || (tick && ms_q == hold_q - 16'd1))
        state_d = ben_q ? BOUNCE_OUT : DONE;
      BOUNCE_OUT: if (tick && ms_q == BOUNCE_LAST) state_d = DONE;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase

    // Prescaler and tick count both restart on every state change.
    if (state_d != state_q) begin
      presc_d = '0;
      ms_d    = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      ms_d    = tick ? ms_q + 16'd1 : ms_q;
    end

    in_bounce = (state_q == BOUNCE_IN) || (state_q == BOUNCE_OUT);
    lfsr_d    = in_bounce ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]}
                          : lfsr_q;

    // Look one cycle ahead so the closing cycle of BOUNCE_OUT already shows release.
    last_bounce_next = (presc_d == PRESC_MAX) && (ms_d == BOUNCE_LAST);
    case (state_d)
      HOLD:      pressed_d = 1'b1;
      BOUNCE_IN: pressed_d = (state_q == BOUNCE_IN) ? lfsr_q[0] : pressed_q;
      BOUNCE_OUT: begin
        pressed_d = (state_q == BOUNCE_OUT) ? lfsr_q[0] : pressed_q;
        if (last_bounce_next) pressed_d = 1'b0;
      end
      default:   pressed_d = 1'b0;
    endcase

    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      ms_q      <= '0;
      lfsr_q    <= 8'hA5;
      key_q     <= '0;
      hold_q    <= '0;
      ben_q     <= 1'b0;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      ms_q      <= ms_d;
      lfsr_q    <= lfsr_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      ben_q     <= ben_d;
      pressed_q <= pressed_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // Zero-latency row return so the scanner sees the key within its own scan cycle.
  always_comb begin
    row = 4'hF;
    if (pressed_q && !col[key_q[1:0]]) row[key_q[3:2]] = 1'b0;
  end

  assign pressed   = pressed_q;
  assign done      = done_q;
  assign req_ready = ready_q;

endmodule
